// File: rtl/line_draw_scheduler.sv
// Queues line commands, sequences them one at a time through an external line engine,
// and clips the engine's pixels into a ready/valid pixel write stream.
module line_draw_scheduler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_x0,
    input  logic [31:0] cmd_y0,
    input  logic [31:0] cmd_x1,
    input  logic [31:0] cmd_y1,
    input  logic [7:0]  cmd_color,

    output logic        bres_start,
    output logic [31:0] bres_x0,
    output logic [31:0] bres_y0,
    output logic [31:0] bres_x1,
    output logic [31:0] bres_y1,
    output logic        bres_enable,
    input  logic        bres_plot,
    input  logic [31:0] bres_x,
    input  logic [31:0] bres_y,
    input  logic        bres_done,

    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [7:0]  pix_color,

    output logic        busy,
    output logic [15:0] lines_done
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] x0;
        logic [31:0] y0;
        logic [31:0] x1;
        logic [31:0] y1;
        logic [7:0]  color;
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StLoad, StDraw, StDrain} state_e;

    cmd_t            fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;

    state_e          state_q, state_d;
    cmd_t            cur_q;

    logic            pix_valid_q;
    logic [9:0]      pix_x_q;
    logic [8:0]      pix_y_q;
    logic [7:0]      pix_color_q;
    logic [15:0]     lines_done_q;

    logic            fifo_empty, fifo_full;
    logic            push, pop;
    logic            line_end;
    logic            in_range, load_pix;
    cmd_t            cmd_in;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PtrW+1)'(FIFO_DEPTH));
    assign cmd_ready  = ~fifo_full;
    assign push       = cmd_valid & ~fifo_full;

    assign cmd_in = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, color: cmd_color};

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        bres_start  = 1'b0;
        bres_enable = 1'b0;
        line_end    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                bres_start = 1'b1;
                state_d    = StDraw;
            end
            StDraw: begin
                // Engine may only step when the output register can take a new pixel.
                bres_enable = ~pix_valid_q | pix_ready;
                if (bres_enable && bres_done) begin
                    line_end = 1'b1;
                    state_d  = StDrain;
                end
            end
            StDrain: begin
                if (!pix_valid_q || pix_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_range = (bres_x < 32'(SCREEN_W)) && (bres_y < 32'(SCREEN_H));
    assign load_pix = bres_enable & bres_plot & in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                count_q <= count_q + (PtrW+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PtrW+1)'(1);
            end
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= cmd_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cur_q        <= '0;
            lines_done_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop)      cur_q        <= fifo_q[rd_ptr_q];
            if (line_end) lines_done_q <= lines_done_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= '0;
        end else if (load_pix) begin
            pix_valid_q <= 1'b1;
            pix_x_q     <= bres_x[9:0];
            pix_y_q     <= bres_y[8:0];
            pix_color_q <= cur_q.color;
        end else if (pix_valid_q && pix_ready) begin
            pix_valid_q <= 1'b0;
        end
    end

    assign bres_x0    = cur_q.x0;
    assign bres_y0    = cur_q.y0;
    assign bres_x1    = cur_q.x1;
    assign bres_y1    = cur_q.y1;

    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_color  = pix_color_q;

    assign busy       = ~fifo_empty | (state_q != StIdle);
    assign lines_done = lines_done_q;

endmodule

// File: tb/tb_line_draw_scheduler.sv
// Bench for line_draw_scheduler: behavioural line engine, pixel scoreboard fed by a
// line-point model, vector table plus stall, reset and random sequences.
module tb_line_draw_scheduler;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [7:0]  cmd_color;
    logic        bres_start;
    logic [31:0] bres_x0, bres_y0, bres_x1, bres_y1;
    logic        bres_enable;
    logic        bres_plot;
    logic [31:0] bres_x, bres_y;
    logic        bres_done;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [7:0]  pix_color;
    logic        busy;
    logic [15:0] lines_done;

    line_draw_scheduler #(
        .FIFO_DEPTH(4),
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_y0     (cmd_y0),
        .cmd_x1     (cmd_x1),
        .cmd_y1     (cmd_y1),
        .cmd_color  (cmd_color),
        .bres_start (bres_start),
        .bres_x0    (bres_x0),
        .bres_y0    (bres_y0),
        .bres_x1    (bres_x1),
        .bres_y1    (bres_y1),
        .bres_enable(bres_enable),
        .bres_plot  (bres_plot),
        .bres_x     (bres_x),
        .bres_y     (bres_y),
        .bres_done  (bres_done),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_color  (pix_color),
        .busy       (busy),
        .lines_done (lines_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- line engine (same reset net as the scheduler) ----------------
    int   e_x, e_y, e_x1, e_y1, e_dx, e_dy, e_sx, e_sy, e_err, e2;
    logic e_act;

    function automatic int absd(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? int'(a - b) : int'(b - a);
    endfunction

    always_comb e2 = 2 * e_err;

    assign bres_plot = e_act;
    assign bres_x    = 32'(e_x);
    assign bres_y    = 32'(e_y);
    assign bres_done = e_act && (e_x == e_x1) && (e_y == e_y1);

    always @(posedge clk) begin
        if (reset) begin
            e_act <= 1'b0;
        end else if (bres_start) begin
            e_x   <= int'(bres_x0);
            e_y   <= int'(bres_y0);
            e_x1  <= int'(bres_x1);
            e_y1  <= int'(bres_y1);
            e_dx  <= absd(bres_x0, bres_x1);
            e_dy  <= -absd(bres_y0, bres_y1);
            e_sx  <= (bres_x0 < bres_x1) ? 1 : -1;
            e_sy  <= (bres_y0 < bres_y1) ? 1 : -1;
            e_err <= absd(bres_x0, bres_x1) - absd(bres_y0, bres_y1);
            e_act <= 1'b1;
        end else if (e_act && bres_enable) begin
            if (bres_done) begin
                e_act <= 1'b0;
            end else begin
                e_err <= e_err + ((e2 >= e_dy) ? e_dy : 0) + ((e2 <= e_dx) ? e_dx : 0);
                if (e2 >= e_dy) e_x <= e_x + e_sx;
                if (e2 <= e_dx) e_y <= e_y + e_sy;
            end
        end
    end

    // ---------------- reference model: expected pixel stream ----------------
    typedef struct {
        int         x;
        int         y;
        logic [7:0] c;
    } pix_t;

    pix_t exp_q[$];

    // Walks the line point by point and keeps only on-screen points, in draw order.
    task automatic model_line(input int x0, input int y0, input int x1, input int y1,
                              input logic [7:0] c);
        int x, y, dx, dy, sx, sy, err, ee, n;
        x   = x0;
        y   = y0;
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        n   = (dx > -dy) ? dx : -dy;
        for (int i = 0; i <= n; i++) begin
            if (x < SCREEN_W && y < SCREEN_H) exp_q.push_back('{x: x, y: y, c: c});
            ee = 2 * err;
            if (ee >= dy) begin err += dy; x += sx; end
            if (ee <= dx) begin err += dx; y += sy; end
        end
    endtask

    // ---------------- pix_ready driver ----------------
    int rdy_mode = 0;  // 0 always, 1 pattern 1-0-0, 2 never, 3 random, 4 until 39 accepted
    int rdy_ph   = 0;
    int acc_cnt  = 0;
    int plot_cnt = 0;

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: pix_ready = 1'b1;
                1: begin
                    pix_ready = (rdy_ph == 0);
                    rdy_ph    = (rdy_ph + 1) % 3;
                end
                2: pix_ready = 1'b0;
                3: pix_ready = 1'($urandom_range(0, 1));
                default: pix_ready = (acc_cnt < 39);
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        pix_t e;
        logic [63:0] act_p, exp_p;
        if (!reset) begin
            if (bres_enable && bres_plot) plot_cnt++;
            if (pix_valid && !pix_ready) check("enable_during_stall", 64'(bres_enable), 64'd0);
            if (pix_valid && pix_ready) begin
                acc_cnt++;
                act_p = {37'd0, pix_x, pix_y, pix_color};
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", act_p, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e     = exp_q.pop_front();
                    exp_p = {37'd0, e.x[9:0], e.y[8:0], e.c};
                    check("pixel", act_p, exp_p);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        acc_cnt  = 0;
        plot_cnt = 0;
    endtask

    task automatic offer(input int x0, input int y0, input int x1, input int y1,
                         input logic [7:0] c, input int budget, output bit ok);
        bit rdy;
        cmd_x0    = 32'(x0);
        cmd_y0    = 32'(y0);
        cmd_x1    = 32'(x1);
        cmd_y1    = 32'(y1);
        cmd_color = c;
        cmd_valid = 1'b1;
        ok        = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        if (ok) begin
            cmd_valid = 1'b0;
            model_line(x0, y0, x1, y1, c);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        check("idle_timeout", 64'(done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int         x0, y0, x1, y1;
        logic [7:0] c;
        int         mode;
        int         exp_plots;
        int         exp_pix;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit ok;
        bit found;
        int n_acc;
        int snap;

        vecs[0] = '{x0: 120, y0: 70,  x1: 0,   y1: 10,  c: 8'h3C, mode: 0, exp_plots: 121, exp_pix: 121};
        vecs[1] = '{x0: 120, y0: 70,  x1: 0,   y1: 10,  c: 8'h3C, mode: 1, exp_plots: 121, exp_pix: 121};
        vecs[2] = '{x0: 630, y0: 5,   x1: 650, y1: 5,   c: 8'hA5, mode: 0, exp_plots: 21,  exp_pix: 10};
        vecs[3] = '{x0: 5,   y0: 470, x1: 5,   y1: 490, c: 8'h11, mode: 3, exp_plots: 21,  exp_pix: 10};
        vecs[4] = '{x0: 7,   y0: 9,   x1: 7,   y1: 9,   c: 8'h01, mode: 0, exp_plots: 1,   exp_pix: 1};
        vecs[5] = '{x0: 300, y0: 10,  x1: 290, y1: 40,  c: 8'hF0, mode: 3, exp_plots: 31,  exp_pix: 31};

        cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_cmd_ready",  64'(cmd_ready),   64'd1);
        check("rst_bres_start", 64'(bres_start),  64'd0);
        check("rst_enable",     64'(bres_enable), 64'd0);
        check("rst_pix_valid",  64'(pix_valid),   64'd0);
        check("rst_pix_data",   64'({pix_x, pix_y, pix_color}), 64'd0);
        check("rst_endpoints",  {bres_x0[15:0], bres_y0[15:0], bres_x1[15:0], bres_y1[15:0]}, 64'd0);
        check("rst_busy",       64'(busy),        64'd0);
        check("rst_lines_done", 64'(lines_done),  64'd0);

        // Single lines from the table
        for (int v = 0; v < 6; v++) begin
            do_reset();
            rdy_mode = vecs[v].mode;
            offer(vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, vecs[v].c, 4, ok);
            check("accept", 64'(ok), 64'd1);
            @(negedge clk);
            check("start_not_yet", 64'(bres_start), 64'd0);
            check("busy_after_push", 64'(busy), 64'd1);
            @(negedge clk);
            check("start_pulse", 64'(bres_start), 64'd1);
            check("start_endpoints",
                  {bres_x0[15:0], bres_y0[15:0], bres_x1[15:0], bres_y1[15:0]},
                  {16'(vecs[v].x0), 16'(vecs[v].y0), 16'(vecs[v].x1), 16'(vecs[v].y1)});
            @(negedge clk);
            check("start_one_cycle", 64'(bres_start), 64'd0);
            wait_idle(2000);
            check("plots",      64'(plot_cnt),     64'(vecs[v].exp_plots));
            check("pix_count",  64'(acc_cnt),      64'(vecs[v].exp_pix));
            check("lines_done", 64'(lines_done),   64'd1);
            check("busy_end",   64'(busy),         64'd0);
            check("model_left", 64'(exp_q.size()), 64'd0);
        end

        // Commands offered while the engine is stalled on a first (stalling) line
        do_reset();
        rdy_mode = 2;
        offer(10, 10, 14, 10, 8'h55, 4, ok);
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (pix_valid) found = 1'b1;
        end
        check("stall_pixel_pending", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            offer(i * 3, 20 + i, i * 3 + 4, 20 + i, 8'(8'h60 + i), 1, ok);
            if (ok) n_acc++;
        end
        check("accepted_while_stalled", 64'(n_acc), 64'd4);
        offer(40, 30, 44, 34, 8'h6F, 6, ok);
        check("fifth_blocked", 64'(ok), 64'd0);
        @(negedge clk);
        check("fifth_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        offer(40, 30, 44, 34, 8'h6F, 300, ok);
        check("fifth_accept", 64'(ok), 64'd1);
        wait_idle(2000);
        // The stalling line plus the five offered ones
        check("stall_lines_done", 64'(lines_done),   64'd6);
        check("stall_model_left", 64'(exp_q.size()), 64'd0);

        // Reset mid-line with the 40th pixel pending and two commands queued
        do_reset();
        rdy_mode = 4;
        offer(0, 0, 100, 0, 8'h77, 4, ok);
        offer(0, 5, 10, 5, 8'h78, 4, ok);
        offer(0, 6, 10, 6, 8'h79, 4, ok);
        found = 1'b0;
        for (int t = 0; t < 400 && !found; t++) begin
            @(negedge clk);
            if (pix_valid && !pix_ready && pix_x == 10'd39) found = 1'b1;
        end
        check("pixel40_pending", 64'(found), 64'd1);
        check("accepted_before_reset", 64'(acc_cnt), 64'd39);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        check("mid_rst_pix_valid",  64'(pix_valid),  64'd0);
        check("mid_rst_busy",       64'(busy),       64'd0);
        check("mid_rst_lines_done", 64'(lines_done), 64'd0);
        check("mid_rst_cmd_ready",  64'(cmd_ready),  64'd1);
        snap = acc_cnt;
        repeat (200) @(negedge clk);
        check("no_pixels_after_reset", 64'(acc_cnt), 64'(snap));
        check("busy_after_reset",      64'(busy),    64'd0);
        @(posedge clk);
        #1;

        // Random commands with random pixel back-pressure
        do_reset();
        rdy_mode = 3;
        for (int i = 0; i < 20; i++) begin
            int rx0, ry0, rx1, ry1;
            rx0 = 20 + int'($urandom_range(0, 680));
            ry0 = 20 + int'($urandom_range(0, 480));
            rx1 = rx0 + int'($urandom_range(0, 40)) - 20;
            ry1 = ry0 + int'($urandom_range(0, 40)) - 20;
            offer(rx0, ry0, rx1, ry1, 8'($urandom_range(0, 255)), 400, ok);
            check("rand_accept", 64'(ok), 64'd1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle(10000);
        check("rand_lines_done", 64'(lines_done),   64'd20);
        check("rand_model_left", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
